mult32x32_arbiter: RTL and testbench

//   Shares one mult32x32 multiplier between NUM_REQ independent requesters.

---
 rtl/mult32x32_arbiter_if.sv | 23 ++
 rtl/mult32x32_arbiter.sv | 113 +++++++++++
 tb/tb_mult32x32_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult32x32_arbiter_if.sv
// Client-side bus of the shared-multiplier arbiter: packed per-requester
// request/operand lanes plus the ack/done/result return path.
interface mult32x32_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req;
   logic [32*NUM_REQ-1:0] a_in;
   logic [32*NUM_REQ-1:0] b_in;
   logic [NUM_REQ-1:0]    ack;
   logic [NUM_REQ-1:0]    done;
   logic [63:0]           result;
   logic                  arb_busy;

   modport master (
      output req, a_in, b_in,
      input  ack, done, result, arb_busy
   );

   modport slave (
      input  req, a_in, b_in,
      output ack, done, result, arb_busy
   );
endinterface

// File: rtl/mult32x32_arbiter.sv
// Round-robin arbiter that time-shares one mult32x32 between NUM_REQ clients,
// sequencing its start/busy handshake and returning the product with a done pulse.
module mult32x32_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                clk,
   input  logic                reset,
   mult32x32_arbiter_if.slave  bus,
   output logic                mult_start,
   output logic [31:0]         mult_a,
   output logic [31:0]         mult_b,
   input  logic                mult_busy,
   input  logic [63:0]         mult_prod
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_HI,
      WAIT_LO,
      DELIVER
   } state_t;

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] grant_reg, grant_next;
   logic [IDX_W-1:0] rr_reg, rr_next;
   logic [31:0]      mult_a_reg, mult_a_next;
   logic [31:0]      mult_b_reg, mult_b_next;
   logic [63:0]      result_reg, result_next;
   logic [IDX_W-1:0] pick;
   logic             any_req;

   // Scan downward so the lowest offset from the rr pointer is assigned last and wins.
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = int'(rr_reg) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (bus.req[idx]) begin
            pick    = IDX_W'(idx);
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      rr_next     = rr_reg;
      mult_a_next = mult_a_reg;
      mult_b_next = mult_b_reg;
      result_next = result_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               grant_next  = pick;
               mult_a_next = bus.a_in[32*pick +: 32];
               mult_b_next = bus.b_in[32*pick +: 32];
               state_next  = START;
            end
         end
         START:   state_next = WAIT_HI;
         WAIT_HI: if (mult_busy) state_next = WAIT_LO;
         WAIT_LO: begin
            if (!mult_busy) begin
               result_next = mult_prod;
               state_next  = DELIVER;
            end
         end
         DELIVER: begin
            rr_next    = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + IDX_W'(1);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         grant_reg  <= '0;
         rr_reg     <= '0;
         mult_a_reg <= '0;
         mult_b_reg <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         rr_reg     <= rr_next;
         mult_a_reg <= mult_a_next;
         mult_b_reg <= mult_b_next;
         result_reg <= result_next;
      end
   end

   // ack/done are state decodes, so they are one-hot and exactly one cycle wide.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign bus.ack[gi]  = (state_reg == START)   && (grant_reg == IDX_W'(gi));
         assign bus.done[gi] = (state_reg == DELIVER) && (grant_reg == IDX_W'(gi));
      end
   endgenerate

   assign bus.arb_busy = (state_reg != IDLE);
   assign bus.result   = result_reg;
   assign mult_start   = (state_reg == START);
   assign mult_a       = mult_a_reg;
   assign mult_b       = mult_b_reg;

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Scoreboard bench for mult32x32_arbiter with a behavioural multiplier and
// a round-robin reference model for grant order.
module tb_mult32x32_arbiter;
   localparam int N  = 3;
   localparam int IW = $clog2(N);

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mult_start, mult_busy;
   logic [31:0] mult_a, mult_b;
   logic [63:0] mult_prod;

   always #5 clk = ~clk;

   mult32x32_arbiter_if #(.NUM_REQ(N)) bus ();

   mult32x32_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .mult_start (mult_start),
      .mult_a     (mult_a),
      .mult_b     (mult_b),
      .mult_busy  (mult_busy),
      .mult_prod  (mult_prod)
   );

   // Multiplier model: busy rises on the start edge, stays high mult_lat cycles.
   int mult_lat = 2;
   int mcnt;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mult_busy <= 1'b0;
         mcnt      <= 0;
         mult_prod <= '0;
      end else if (mult_start) begin
         mult_busy <= 1'b1;
         mcnt      <= mult_lat;
         mult_prod <= 64'(mult_a) * 64'(mult_b);
      end else if (mult_busy) begin
         if (mcnt <= 1) mult_busy <= 1'b0;
         else           mcnt <= mcnt - 1;
      end
   end

   int          tests = 0;
   int          fails = 0;
   logic [63:0] exp_q[N][$];
   int          grant_log[$];
   int          ack_cnt = 0;
   int          start_cnt = 0;
   int          rr_model = 0;
   int          cur_g = 0;
   int          eg;
   logic        in_flight = 1'b0;
   logic        done_prev = 1'b0;
   logic [N-1:0] prev_req = '0;
   logic [63:0] exp_ack;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   function automatic int expected_grant(input logic [N-1:0] pr, input int rr);
      for (int k = 0; k < N; k++) begin
         if (pr[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   function automatic int pending_total();
      int s = 0;
      for (int i = 0; i < N; i++) s += exp_q[i].size();
      return s + (in_flight ? 1 : 0);
   endfunction

   // Monitor: checks grant order, one-hot pulses and results against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            rr_model  = 0;
            in_flight = 1'b0;
            done_prev = 1'b0;
         end else begin
            if (done_prev) check("arb_busy_after_done", 64'(bus.arb_busy), 64'd0);
            done_prev = 1'b0;
            if (mult_start) start_cnt++;
            if (bus.ack != '0) begin
               eg      = expected_grant(prev_req, rr_model);
               exp_ack = (eg < 0) ? 64'd0 : (64'd1 << eg);
               ack_cnt++;
               check("ack_grant", 64'(bus.ack), exp_ack);
               check("ack_overlap", 64'(in_flight), 64'd0);
               check("ack_with_start", 64'(mult_start), 64'd1);
               in_flight = 1'b1;
               cur_g     = (eg < 0) ? 0 : eg;
               grant_log.push_back(cur_g);
            end
            if (bus.done != '0) begin
               check("done_lane", 64'(bus.done), 64'd1 << cur_g);
               check("done_in_flight", 64'(in_flight), 64'd1);
               if (exp_q[cur_g].size() == 0) begin
                  check("done_unexpected", 64'(bus.done), 64'd0);
               end else begin
                  check("result", bus.result, exp_q[cur_g].pop_front());
               end
               $display("[TB] done req%0d result=%h", cur_g, bus.result);
               rr_model  = (cur_g + 1) % N;
               in_flight = 1'b0;
               done_prev = 1'b1;
            end
         end
         prev_req = bus.req;
      end
   end

   task automatic client_op(input int i, input logic [31:0] a, input logic [31:0] b);
      int waited = 0;
      @(posedge clk); #1;
      bus.a_in[32*i +: 32] = a;
      bus.b_in[32*i +: 32] = b;
      bus.req[i]           = 1'b1;
      exp_q[i].push_back(64'(a) * 64'(b));
      $display("[TB] issue req%0d a=%h b=%h", i, a, b);
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.ack[i] && waited < 400);
      if (!bus.ack[i]) check("ack_timeout", 64'(waited), 64'd0);
      @(posedge clk); #1;
      bus.req[i] = 1'b0;
   endtask

   task automatic drain();
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (pending_total() != 0 && c < 2000);
      check("drain_empty", 64'(pending_total()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 3))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_arb_busy", 64'(bus.arb_busy), 64'd0);
      check("rst_result", bus.result, 64'd0);
      check("rst_ack", 64'(bus.ack), 64'd0);
      check("rst_mult_start", 64'(mult_start), 64'd0);
      reset = 1'b1;

      // Basic products including the all-ones corner.
      client_op(0, 32'd3, 32'd5);
      drain();
      client_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();

      // Reset while waiting for busy to fall: everything clears, no done.
      mult_lat = 8;
      client_op(0, 32'h0001_2345, 32'h0006_789A);
      @(posedge clk);
      @(negedge clk);
      check("mid_op_busy", 64'(bus.arb_busy), 64'd1);
      reset = 1'b0;
      #1;
      check("rst_mid_ack", 64'(bus.ack), 64'd0);
      check("rst_mid_done", 64'(bus.done), 64'd0);
      check("rst_mid_start", 64'(mult_start), 64'd0);
      check("rst_mid_busy", 64'(bus.arb_busy), 64'd0);
      check("rst_mid_result", bus.result, 64'd0);
      check("rst_mid_mult_a", 64'(mult_a), 64'd0);
      check("rst_mid_mult_b", 64'(mult_b), 64'd0);
      exp_q[0].delete();
      repeat (2) @(negedge clk);
      reset    = 1'b1;
      mult_lat = 2;

      // Simultaneous requests straight out of reset: req0 first.
      grant_log.delete();
      fork
         client_op(0, 32'd0, 32'd7);
         client_op(1, 32'h8000_0000, 32'd2);
      join
      drain();
      check("sim_order_0", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
      check("sim_order_1", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'd1);

      // Two continuously requesting clients alternate.
      grant_log.delete();
      fork
         begin repeat (3) client_op(0, rand_operand(), rand_operand()); end
         begin repeat (3) client_op(1, rand_operand(), rand_operand()); end
      join
      drain();
      check("alt_count", 64'(grant_log.size()), 64'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < grant_log.size()) check("alt_grant", 64'(grant_log[k]), 64'(k % 2));
      end

      // req1 arrives while req0 is in flight: served strictly afterwards.
      grant_log.delete();
      fork
         client_op(0, 32'h1234_5678, 32'h9ABC_DEF0);
         begin repeat (3) @(posedge clk); client_op(1, 32'hDEAD_BEEF, 32'h0000_0010); end
      join
      drain();
      check("pend_order_0", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
      check("pend_order_1", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'd1);

      // Randomised traffic from every client with varying multiplier latency.
      fork
         for (int c = 0; c < N; c++) begin
            fork
               automatic int ci = c;
               begin
                  for (int n = 0; n < 15; n++) begin
                     repeat ($urandom_range(0, 6)) @(posedge clk);
                     mult_lat = $urandom_range(1, 6);
                     client_op(ci, rand_operand(), rand_operand());
                  end
               end
            join_none
         end
      join
      wait fork;
      drain();
      check("start_per_ack", 64'(start_cnt), 64'(ack_cnt));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
